// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode values, instruction-register field positions and the
// fetch FSM state encoding.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] SWP    = 4'd3;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] BNR    = 4'd7;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 28;
  localparam int unsigned MmMsb     = 27;
  localparam int unsigned MmLsb     = 24;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sisc_pc_next.sv
// Combinational next-PC: increment, absolute branch target or PC-relative branch target.
module sisc_pc_next #(
  parameter int unsigned PC_W = 16
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [15:0]     imm_i,
  input  logic            pc_sel_i,
  input  logic            br_sel_i,
  output logic [PC_W-1:0] pc_next_o
);

  localparam int unsigned ExtW = (PC_W > 16) ? PC_W : 16;

  logic [ExtW-1:0] imm_sext;
  logic [ExtW-1:0] imm_zext;

  assign imm_sext = ExtW'($signed(imm_i));
  assign imm_zext = ExtW'(imm_i);

  // All sums are PC_W wide so wrap-around is implicit.
  always_comb begin
    pc_next_o = pc_i + PC_W'(1);
    if (pc_sel_i) begin
      if (br_sel_i) begin
        pc_next_o = pc_i + imm_sext[PC_W-1:0];
      end else begin
        pc_next_o = imm_zext[PC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction-fetch responder: owns PC and IR, fetches over an im_req/im_ack handshake.
// Define SISC_FETCH_TIMEOUT_EN to abort fetches that see no im_ack within TIMEOUT cycles.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int unsigned    PC_W     = 16,
  parameter int unsigned    IR_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned    TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            ir_load,
  input  logic            im_ack,
  input  logic [IR_W-1:0] im_rdata,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  output logic [PC_W-1:0] pc,
  output logic [IR_W-1:0] ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [15:0]     imm,
  output logic            busy,
  output logic            err
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            err_q, err_d;
  logic            accept;
  logic [PC_W-1:0] pc_next;

`ifdef SISC_FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;

  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q != StIdle && !im_ack) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ir_load) begin
          state_d = StReq;
          addr_d  = pc_q;
          accept  = 1'b1;
        end
        if (im_ack) begin
          err_d = 1'b1;
        end
      end
      StReq, StWait: begin
        if (ir_load) begin
          err_d = 1'b1;
        end
        if (im_ack) begin
          ir_d    = im_rdata;
          state_d = StIdle;
        end
`ifdef SISC_FETCH_TIMEOUT_EN
        else if (timeout_hit) begin
          ir_d    = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end
`endif
        else begin
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
    // PC reset aborts any fetch in flight and leaves IR untouched.
    if (pc_rst) begin
      state_d = StIdle;
      addr_d  = addr_q;
      ir_d    = ir_q;
      accept  = 1'b0;
    end
  end

  sisc_pc_next #(
    .PC_W(PC_W)
  ) u_pc_next (
    .pc_i     (pc_q),
    .imm_i    (ir_q[ImmMsb:ImmLsb]),
    .pc_sel_i (pc_sel),
    .br_sel_i (br_sel),
    .pc_next_o(pc_next)
  );

  always_comb begin
    pc_d = pc_q;
    if (pc_rst) begin
      pc_d = RESET_PC;
    end else if (pc_write) begin
      pc_d = pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign im_req  = (state_q != StIdle);
  assign busy    = (state_q != StIdle) | accept;
  assign im_addr = addr_q;
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign opcode  = ir_q[OpcodeMsb:OpcodeLsb];
  assign mm      = ir_q[MmMsb:MmLsb];
  assign imm     = ir_q[ImmMsb:ImmLsb];
  assign err     = err_q;

endmodule
